// File: rtl/mcpu_mem_arbiter.sv
// mcpu_mem_arbiter: shares the MCPU's single-port synchronous-read RAM
// between instruction fetch (port 0), data load/store (port 1) and the host
// loader (port 2). One access in flight at a time. Reads return two cycles
// after the request is sampled.
module mcpu_mem_arbiter #(
  parameter int WORD_SIZE  = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [2:0]              req,
  input  logic [2:0]              we,
  input  logic [3*ADDR_WIDTH-1:0] addr,
  input  logic [3*WORD_SIZE-1:0]  wdata,
  output logic [2:0]              gnt,
  output logic [2:0]              rvalid,
  output logic [WORD_SIZE-1:0]    rdata,
  output logic                    busy,
  output logic                    ram_en,
  output logic                    ram_we,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [WORD_SIZE-1:0]    ram_wdata,
  input  logic [WORD_SIZE-1:0]    ram_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;

  logic                    win_vld;
  logic [1:0]              win_idx_nxt;
  logic                    sel_we;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [WORD_SIZE-1:0]    sel_wdata;

  // Latched command of the current winner
  logic [1:0]              win_idx_p0;
  logic                    cmd_we_p0;
  logic [ADDR_WIDTH-1:0]   cmd_addr_p0;
  logic [WORD_SIZE-1:0]    cmd_wdata_p0;

  // 1 = port 1 wins a 0/1 tie, 0 = port 0 wins it
  logic                    rr_ptr;

  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    logic [2:0] v;
    v = 3'b000;
    case (idx)
      2'd0:    v = 3'b001;
      2'd1:    v = 3'b010;
      2'd2:    v = 3'b100;
      default: v = 3'b000;
    endcase
    return v;
  endfunction

  // Pick a winner: loader first, then round-robin between fetch and data
  always_comb begin
    win_vld     = ((state == IDLE) || (state == RESP)) && (req != 3'b000);
    win_idx_nxt = 2'd0;
    if (req[2])
      win_idx_nxt = 2'd2;
    else if (req[0] && req[1])
      win_idx_nxt = {1'b0, rr_ptr};
    else if (req[1])
      win_idx_nxt = 2'd1;
    else
      win_idx_nxt = 2'd0;
  end

  // Route the winning port's command fields
  always_comb begin
    sel_we    = we[0];
    sel_addr  = addr[ADDR_WIDTH-1:0];
    sel_wdata = wdata[WORD_SIZE-1:0];
    case (win_idx_nxt)
      2'd1: begin
        sel_we    = we[1];
        sel_addr  = addr[2*ADDR_WIDTH-1:ADDR_WIDTH];
        sel_wdata = wdata[2*WORD_SIZE-1:WORD_SIZE];
      end
      2'd2: begin
        sel_we    = we[2];
        sel_addr  = addr[3*ADDR_WIDTH-1:2*ADDR_WIDTH];
        sel_wdata = wdata[3*WORD_SIZE-1:2*WORD_SIZE];
      end
      default: ;
    endcase
  end

  // State register and control latches; loader wins leave the pointer alone
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      win_idx_p0 <= 2'd0;
      cmd_we_p0  <= 1'b0;
      rr_ptr     <= 1'b1;
    end else begin
      state <= state_nxt;
      if (win_vld) begin
        win_idx_p0 <= win_idx_nxt;
        cmd_we_p0  <= sel_we;
        if (win_idx_nxt != 2'd2)
          rr_ptr <= ~win_idx_nxt[0];
      end
    end
  end

  // Command address/data capture; outputs are gated by state so no reset needed
  always_ff @(posedge clk) begin
    if (win_vld) begin
      cmd_addr_p0  <= sel_addr;
      cmd_wdata_p0 <= sel_wdata;
    end
  end

  // Next-state: writes skip RESP, RESP can chain straight into another ISSUE
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = win_vld ? ISSUE : IDLE;
      ISSUE:   state_nxt = cmd_we_p0 ? IDLE : RESP;
      RESP:    state_nxt = win_vld ? ISSUE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state and latched command only
  always_comb begin
    gnt       = 3'b000;
    rvalid    = 3'b000;
    busy      = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (state)
      ISSUE: begin
        gnt       = onehot3(win_idx_p0);
        busy      = 1'b1;
        ram_en    = 1'b1;
        ram_we    = cmd_we_p0;
        ram_addr  = cmd_addr_p0;
        ram_wdata = cmd_wdata_p0;
      end
      RESP: begin
        rvalid = onehot3(win_idx_p0);
        busy   = 1'b1;
      end
      default: ;
    endcase
  end

  assign rdata = ram_rdata;

endmodule

// File: tb/tb_mcpu_mem_arbiter.sv
// Testbench for mcpu_mem_arbiter: behavioural RAM, directed requester steps,
// and a monitor that checks every gnt/rvalid against expectation queues.
module tb_mcpu_mem_arbiter;

  localparam int WS = 16;
  localparam int AW = 8;

  logic            clk;
  logic            reset;
  logic [2:0]      req;
  logic [2:0]      we;
  logic [3*AW-1:0] addr;
  logic [3*WS-1:0] wdata;
  logic [2:0]      gnt;
  logic [2:0]      rvalid;
  logic [WS-1:0]   rdata;
  logic            busy;
  logic            ram_en;
  logic            ram_we;
  logic [AW-1:0]   ram_addr;
  logic [WS-1:0]   ram_wdata;
  logic [WS-1:0]   ram_rdata;

  // RAM model with a preload port used while the arbiter is held in reset
  logic [WS-1:0]   mem [256];
  logic            pl_en;
  logic [AW-1:0]   pl_addr;
  logic [WS-1:0]   pl_data;

  int n_assert = 0;
  int n_fail   = 0;

  int          exp_gnt_q[$];
  logic [17:0] exp_rsp_q[$];

  mcpu_mem_arbiter #(.WORD_SIZE(WS), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en)
      mem[pl_addr] <= pl_data;
    else if (ram_en) begin
      if (ram_we)
        mem[ram_addr] <= ram_wdata;
      else
        ram_rdata <= mem[ram_addr];
    end
  end

  function automatic logic [2:0] oh(input int p);
    logic [2:0] v;
    v = 3'b000;
    if (p >= 0 && p < 3) v[p] = 1'b1;
    return v;
  endfunction

  // Scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    int          ep;
    logic [17:0] er;
    n_assert++;
    assert (((gnt & rvalid) == 3'b000) && $onehot0(gnt) && $onehot0(rvalid)) else begin
      n_fail++;
      $error("FAIL onehot gnt=%b rvalid=%b required disjoint one-hot", gnt, rvalid);
    end
    if (gnt != 3'b000) begin
      ep = (exp_gnt_q.size() > 0) ? exp_gnt_q.pop_front() : -1;
      n_assert++;
      assert (gnt === oh(ep)) else begin
        n_fail++;
        $error("FAIL gnt_order got=%b exp=%b", gnt, oh(ep));
      end
    end
    if (rvalid != 3'b000) begin
      er = (exp_rsp_q.size() > 0) ? exp_rsp_q.pop_front() : 18'h3ffff;
      n_assert++;
      assert ((rvalid === oh(int'(er[17:16]))) && (rdata === er[15:0])) else begin
        n_fail++;
        $error("FAIL rsp got port=%b data=%h exp port=%b data=%h",
               rvalid, rdata, oh(int'(er[17:16])), er[15:0]);
      end
    end
  end

  task automatic set_cmd(input int p, input logic w, input logic [AW-1:0] a,
                         input logic [WS-1:0] d);
    we[p]            = w;
    addr[p*AW +: AW] = a;
    wdata[p*WS +: WS] = d;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [WS-1:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for gnt[p] at falling edges and checks how many edges it took
  task automatic wait_gnt(input int p, input int exp_lat, input string tag);
    int lat;
    bit seen;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 16) begin
      @(negedge clk);
      lat++;
      if (gnt[p]) seen = 1'b1;
    end
    n_assert++;
    assert (seen && lat == exp_lat) else begin
      n_fail++;
      $error("FAIL %s gnt latency got=%0d exp=%0d", tag, seen ? lat : -1, exp_lat);
    end
  endtask

  initial begin
    int cyc;
    int last;
    int cnt;

    reset = 1'b0;
    req   = 3'b000;
    we    = 3'b000;
    addr  = '0;
    wdata = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    ram_rdata = '0;

    @(negedge clk);
    preload(8'h00, 16'h1003);
    preload(8'h10, 16'hA0A0);
    preload(8'h11, 16'hB1B1);
    preload(8'h20, 16'hC2C2);
    preload(8'h30, 16'hD3D3);

    // Reset values with all ports requesting
    set_cmd(0, 1'b0, 8'h10, 16'h0);
    set_cmd(1, 1'b0, 8'h11, 16'h0);
    set_cmd(2, 1'b0, 8'h00, 16'h0);
    req = 3'b111;
    repeat (2) begin
      @(negedge clk);
      check("rst_gnt",    32'(gnt),    32'h0);
      check("rst_rvalid", 32'(rvalid), 32'h0);
      check("rst_ram_en", 32'(ram_en), 32'h0);
      check("rst_busy",   32'(busy),   32'h0);
    end
    exp_gnt_q.push_back(2);
    exp_rsp_q.push_back({2'd2, 16'h1003});
    reset = 1'b1;
    wait_gnt(2, 1, "post_rst_loader");
    req = 3'b000;
    repeat (3) @(negedge clk);

    // Single fetch read
    exp_gnt_q.push_back(0);
    exp_rsp_q.push_back({2'd0, 16'h1003});
    set_cmd(0, 1'b0, 8'h00, 16'h0);
    req[0] = 1'b1;
    wait_gnt(0, 1, "fetch_gnt");
    check("fetch_ram_addr", 32'(ram_addr), 32'h00);
    req[0] = 1'b0;
    @(negedge clk);
    check("fetch_rvalid", {13'h0, rvalid, rdata}, {13'h0, 3'b001, 16'h1003});
    repeat (2) @(negedge clk);

    // Loader write then fetch read of the same word
    exp_gnt_q.push_back(2);
    set_cmd(2, 1'b1, 8'h01, 16'h2201);
    req[2] = 1'b1;
    wait_gnt(2, 1, "ld_wr_gnt");
    check("ld_wr_ram_we",    32'(ram_we),    32'h1);
    check("ld_wr_ram_addr",  32'(ram_addr),  32'h01);
    check("ld_wr_ram_wdata", 32'(ram_wdata), 32'h2201);
    req[2] = 1'b0;
    exp_gnt_q.push_back(0);
    exp_rsp_q.push_back({2'd0, 16'h2201});
    set_cmd(0, 1'b0, 8'h01, 16'h0);
    req[0] = 1'b1;
    wait_gnt(0, 2, "fetch_after_wr");
    req[0] = 1'b0;
    repeat (3) @(negedge clk);

    // Round-robin between fetch and data
    set_cmd(0, 1'b0, 8'h10, 16'h0);
    set_cmd(1, 1'b0, 8'h11, 16'h0);
    for (int i = 0; i < 6; i++) begin
      exp_gnt_q.push_back((i % 2 == 0) ? 1 : 0);
      exp_rsp_q.push_back((i % 2 == 0) ? {2'd1, 16'hB1B1} : {2'd0, 16'hA0A0});
    end
    req[1:0] = 2'b11;
    cyc = 0; last = 0; cnt = 0;
    while (cnt < 6 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (gnt != 3'b000) begin
        if (cnt == 0) check("rr_first_lat", 32'(cyc), 32'd1);
        else          check("rr_gap", 32'(cyc - last), 32'd2);
        last = cyc;
        cnt++;
      end
    end
    req[1:0] = 2'b00;
    check("rr_count", 32'(cnt), 32'd6);
    repeat (3) @(negedge clk);

    // Loader preemption of the fetch/data round-robin
    set_cmd(2, 1'b0, 8'h20, 16'h0);
    exp_gnt_q.push_back(1); exp_rsp_q.push_back({2'd1, 16'hB1B1});
    exp_gnt_q.push_back(2); exp_rsp_q.push_back({2'd2, 16'hC2C2});
    exp_gnt_q.push_back(0); exp_rsp_q.push_back({2'd0, 16'hA0A0});
    exp_gnt_q.push_back(1); exp_rsp_q.push_back({2'd1, 16'hB1B1});
    req[1:0] = 2'b11;
    cyc = 0; cnt = 0;
    while (cnt < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (gnt != 3'b000) begin
        cnt++;
        if (cnt == 1) req[2] = 1'b1;
        if (gnt[2])   req[2] = 1'b0;
      end
    end
    req = 3'b000;
    check("preempt_count", 32'(cnt), 32'd4);
    repeat (3) @(negedge clk);

    // Reset during a read's ISSUE cycle
    exp_gnt_q.push_back(0);
    set_cmd(0, 1'b0, 8'h10, 16'h0);
    req[0] = 1'b1;
    wait_gnt(0, 1, "midrst_gnt");
    reset = 1'b0;
    req   = 3'b000;
    #1;
    check("midrst_ram_en", 32'(ram_en), 32'h0);
    check("midrst_busy",   32'(busy),   32'h0);
    repeat (2) @(negedge clk);
    check("midrst_rvalid", 32'(rvalid), 32'h0);
    reset = 1'b1;
    @(negedge clk);
    check("postrst_idle_rvalid", 32'(rvalid), 32'h0);
    exp_gnt_q.push_back(1);
    exp_rsp_q.push_back({2'd1, 16'hD3D3});
    set_cmd(1, 1'b0, 8'h30, 16'h0);
    req[1] = 1'b1;
    wait_gnt(1, 1, "postrst_gnt");
    req[1] = 1'b0;
    repeat (4) @(negedge clk);

    check("gnt_q_drained", 32'(exp_gnt_q.size()), 32'd0);
    check("rsp_q_drained", 32'(exp_rsp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
